mp_meter: RTL and testbench

- Magic-point (MP) bookkeeping stage that sits directly upstream of the MP bar renderer and drives its 10-bit `magic` fill-extent input.
- Holds the player's MP in bar-pixel units (0..MP_MAX).
- Accepts or denies spell casts against the current MP, regenerates MP over time and supports a full restore.
- Animates the displayed fill one pixel per step toward the true MP, so the bar drains and fills smoothly.

---
 rtl/mp_meter.sv | 194 +++++++++++++++++++
 tb/tb_mp_meter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_meter.sv
// MP bookkeeping for the MP bar: cast accept/deny, regen, restore and a smoothly animated fill extent.
// Optional low-MP blink of the bar is built only when MP_LOW_BLINK_EN is defined.
module mp_meter #(
    parameter int MP_MAX    = 120,
    parameter int STEP_DIV  = 833333,
    parameter int REGEN_DIV = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cast,
    input  logic [6:0] cost,
    input  logic       restore,
    output logic [9:0] magic,
    output logic [6:0] mp,
    output logic       cast_ok,
    output logic       cast_denied,
    output logic       busy,
    output logic       empty
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = (REGEN_DIV > 1) ? $clog2(REGEN_DIV) : 1;
    localparam logic [6:0] MP_FULL = 7'(MP_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   step_q, step_d;
    logic [RW-1:0]   regen_q, regen_d;
    logic [6:0]      mp_q, mp_d;
    logic [6:0]      disp_q, disp_d;
    logic [9:0]      magic_q, magic_d;
    logic            ok_q, ok_d;
    logic            den_q, den_d;
    logic            busy_q;
    logic            empty_q;
    logic            step_wrap_s;
    logic            regen_wrap_s;

    // Free-running divider counters for the animation step and regeneration tick.
    always_comb begin
        step_wrap_s  = (step_q == SW'(STEP_DIV - 1));
        regen_wrap_s = (regen_q == RW'(REGEN_DIV - 1));
        step_d       = step_wrap_s ? SW'(0) : step_q + SW'(1);
    end

    // MP update with priority restore > cast > regen; accepted casts also restart the regen period.
    always_comb begin
        mp_d    = mp_q;
        regen_d = regen_wrap_s ? RW'(0) : regen_q + RW'(1);
        ok_d    = 1'b0;
        den_d   = 1'b0;
        if (restore) begin
            mp_d    = MP_FULL;
            regen_d = RW'(0);
        end else if (cast && (cost <= mp_q)) begin
            mp_d    = mp_q - cost;
            ok_d    = 1'b1;
            regen_d = RW'(0);
        end else begin
            den_d = cast;
            if (regen_wrap_s && (mp_q < MP_FULL)) begin
                mp_d = mp_q + 7'd1;
            end else begin
                mp_d = mp_q;
            end
        end
    end

    // Displayed fill moves one pixel per step strobe in the direction the FSM is animating.
    always_comb begin
        disp_d = disp_q;
        if (step_wrap_s) begin
            case (state_q)
                S_DRAIN: disp_d = (disp_q != 7'd0) ? disp_q - 7'd1 : disp_q;
                S_FILL:  disp_d = (disp_q < MP_FULL) ? disp_q + 7'd1 : disp_q;
                default: disp_d = disp_q;
            endcase
        end else begin
            disp_d = disp_q;
        end
    end

`ifdef MP_LOW_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          low_s;

    // Blink phase toggles every BLINK_DIV cycles; low MP blanks the bar while the phase is set.
    always_comb begin
        blink_d = (blink_q == BW'(BLINK_DIV - 1)) ? BW'(0) : blink_q + BW'(1);
        phase_d = (blink_q == BW'(BLINK_DIV - 1)) ? ~phase_q : phase_q;
        low_s   = ({mp_d, 2'b00} < 9'(MP_MAX));
        if (low_s && phase_d) begin
            magic_d = 10'd2;
        end else begin
            magic_d = {3'b000, disp_d} + 10'd2;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= BW'(0);
            phase_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end
`else
    // Fill extent handed to the renderer: the bar interior starts two pixels in.
    always_comb begin
        magic_d = {3'b000, disp_d} + 10'd2;
    end
`endif

    // Datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= SW'(0);
            regen_q <= RW'(0);
            mp_q    <= MP_FULL;
            disp_q  <= MP_FULL;
            magic_q <= 10'(MP_MAX + 2);
            ok_q    <= 1'b0;
            den_q   <= 1'b0;
            empty_q <= 1'b0;
        end else begin
            step_q  <= step_d;
            regen_q <= regen_d;
            mp_q    <= mp_d;
            disp_q  <= disp_d;
            magic_q <= magic_d;
            ok_q    <= ok_d;
            den_q   <= den_d;
            empty_q <= (mp_d == 7'd0);
        end
    end

    // Animation FSM; decided on next-cycle values so busy lines up with the mp change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (disp_d != mp_d);
            case (state_q)
                S_IDLE: begin
                    if (disp_d > mp_d) begin
                        state_q <= S_DRAIN;
                    end else if (disp_d < mp_d) begin
                        state_q <= S_FILL;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (disp_d == mp_d) begin
                        state_q <= S_IDLE;
                    end else if (disp_d < mp_d) begin
                        state_q <= S_FILL;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_FILL: begin
                    if (disp_d == mp_d) begin
                        state_q <= S_IDLE;
                    end else if (disp_d > mp_d) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_FILL;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign magic       = magic_q;
    assign mp          = mp_q;
    assign cast_ok     = ok_q;
    assign cast_denied = den_q;
    assign busy        = busy_q;
    assign empty       = empty_q;

endmodule

// File: tb/tb_mp_meter.sv
// Self-checking bench for mp_meter: directed scenarios plus randomized traffic against a behavioural model.
module tb_mp_meter;

    localparam int MP_MAX    = 120;
    localparam int STEP_DIV  = 4;
    localparam int REGEN_DIV = 1000;
    localparam int BLINK_DIV = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cast;
    logic [6:0] cost;
    logic       restore;
    logic [9:0] magic;
    logic [6:0] mp;
    logic       cast_ok;
    logic       cast_denied;
    logic       busy;
    logic       empty;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_mp, m_disp, m_step, m_regen, m_blink, m_phase, m_ok, m_den;

    mp_meter #(
        .MP_MAX(MP_MAX), .STEP_DIV(STEP_DIV), .REGEN_DIV(REGEN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .cast(cast), .cost(cost), .restore(restore),
        .magic(magic), .mp(mp), .cast_ok(cast_ok), .cast_denied(cast_denied),
        .busy(busy), .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic int exp_magic();
`ifdef MP_LOW_BLINK_EN
        if ((m_mp * 4 < MP_MAX) && (m_phase == 1)) return 2;
`endif
        return m_disp + 2;
    endfunction

    function automatic int exp_busy();
        return (m_disp != m_mp) ? 1 : 0;
    endfunction

    // Apply one cycle of inputs, advance the model by the spec's rules, sample 1 time unit after the edge.
    task automatic tick(input logic r, input logic c, input logic [6:0] k, input logic s);
        int strobe, wrap, old_mp;
        rst = r; cast = c; cost = k; restore = s;
        @(posedge clk);
        if (r) begin
            m_mp = MP_MAX; m_disp = MP_MAX; m_step = 0; m_regen = 0;
            m_blink = 0; m_phase = 0; m_ok = 0; m_den = 0;
        end else begin
            strobe = (m_step == STEP_DIV - 1);
            m_step = strobe ? 0 : m_step + 1;
            wrap   = (m_regen == REGEN_DIV - 1);
            old_mp = m_mp;
            m_ok = 0; m_den = 0;
            if (s) begin
                m_mp = MP_MAX; m_regen = 0;
            end else if (c && int'(k) <= old_mp) begin
                m_mp = old_mp - int'(k); m_ok = 1; m_regen = 0;
            end else begin
                if (c) m_den = 1;
                if (wrap) begin
                    m_regen = 0;
                    if (m_mp < MP_MAX) m_mp = m_mp + 1;
                end else begin
                    m_regen = m_regen + 1;
                end
            end
            if (strobe) begin
                if (m_disp > old_mp) m_disp = m_disp - 1;
                else if (m_disp < old_mp) m_disp = m_disp + 1;
            end
            if (m_blink == BLINK_DIV - 1) begin
                m_blink = 0; m_phase = 1 - m_phase;
            end else begin
                m_blink = m_blink + 1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic wait_settled(input int bound, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s_settle_timeout busy=%0b want 0 within %0d cycles", tag, busy, bound);
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 7'd0, 1'b0);
        tick(1'b1, 1'b1, 7'd5, 1'b0);
        checks++; if (mp !== 7'd120) begin errors++; $display("FAIL reset_mp got %0d want 120", mp); end
        checks++; if (magic !== 10'd122) begin errors++; $display("FAIL reset_magic got %0d want 122", magic); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty got %0b want 0", empty); end
        checks++; if ({cast_ok, cast_denied} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {cast_ok, cast_denied}); end
    endtask

    task automatic test_cast_drain();
        int prev, last_chg, nchg, cyc;
        tick(1'b0, 1'b0, 7'd0, 1'b0);
        tick(1'b0, 1'b1, 7'd30, 1'b0);
        checks++; if (cast_ok !== 1'b1) begin errors++; $display("FAIL drain_cast_ok got %0b want 1", cast_ok); end
        checks++; if (mp !== 7'd90) begin errors++; $display("FAIL drain_mp got %0d want 90", mp); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %0b want 1", busy); end
        checks++; if (magic !== 10'd122) begin errors++; $display("FAIL drain_magic0 got %0d want 122", magic); end
        prev = 122; last_chg = 0; nchg = 0; cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            cyc++;
            if (cyc == 1) begin
                checks++; if (cast_ok !== 1'b0) begin errors++; $display("FAIL drain_pulse_len got %0b want 0", cast_ok); end
            end
            if (int'(magic) != prev) begin
                checks++; if (int'(magic) != prev - 1) begin errors++; $display("FAIL drain_step got %0d want %0d", magic, prev - 1); end
                if (nchg > 0) begin
                    checks++; if (cyc - last_chg != STEP_DIV) begin errors++; $display("FAIL drain_interval got %0d want %0d", cyc - last_chg, STEP_DIV); end
                end
                nchg++; last_chg = cyc; prev = int'(magic);
            end
            if (int'(magic) != 92) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_early got %0b want 1 at magic %0d", busy, magic); end
            end
        end
        checks++; if (magic !== 10'd92) begin errors++; $display("FAIL drain_final_magic got %0d want 92", magic); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_final_busy got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b1, 7'd50, 1'b0);
        checks++; if ({cast_ok, mp} !== {1'b1, 7'd70}) begin errors++; $display("FAIL b2b_1 got ok=%0b mp=%0d want ok=1 mp=70", cast_ok, mp); end
        tick(1'b0, 1'b1, 7'd50, 1'b0);
        checks++; if ({cast_ok, mp} !== {1'b1, 7'd20}) begin errors++; $display("FAIL b2b_2 got ok=%0b mp=%0d want ok=1 mp=20", cast_ok, mp); end
        tick(1'b0, 1'b1, 7'd50, 1'b0);
        checks++; if ({cast_ok, cast_denied, mp} !== {2'b01, 7'd20}) begin errors++; $display("FAIL b2b_3 got ok=%0b den=%0b mp=%0d want ok=0 den=1 mp=20", cast_ok, cast_denied, mp); end
        tick(1'b0, 1'b1, 7'd0, 1'b0);
        checks++; if ({cast_ok, cast_denied, mp} !== {2'b10, 7'd20}) begin errors++; $display("FAIL b2b_cost0 got ok=%0b den=%0b mp=%0d want ok=1 den=0 mp=20", cast_ok, cast_denied, mp); end
        wait_settled(600, "b2b");
    endtask

    task automatic test_denied();
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b1, 7'd110, 1'b0);
        wait_settled(600, "deny_setup");
        tick(1'b0, 1'b1, 7'd11, 1'b0);
        checks++; if ({cast_ok, cast_denied} !== 2'b01) begin errors++; $display("FAIL deny_pulse got ok=%0b den=%0b want 0 1", cast_ok, cast_denied); end
        checks++; if (mp !== 7'd10) begin errors++; $display("FAIL deny_mp got %0d want 10", mp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deny_busy got %0b want 0", busy); end
        tick(1'b0, 1'b0, 7'd0, 1'b0);
        checks++; if (cast_denied !== 1'b0) begin errors++; $display("FAIL deny_pulse_len got %0b want 0", cast_denied); end
        tick(1'b0, 1'b1, 7'd127, 1'b0);
        checks++; if (cast_denied !== 1'b1) begin errors++; $display("FAIL deny_overmax got %0b want 1", cast_denied); end
    endtask

    task automatic test_regen();
        int n;
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b1, 7'd2, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            if (i == 998 || i == 999 || i == 1998 || i == 1999 || i == 2999) begin
                checks++; if (int'(mp) != m_mp) begin errors++; $display("FAIL regen_mp_c%0d got %0d want %0d", i, mp, m_mp); end
            end
        end
        checks++; if (mp !== 7'd120) begin errors++; $display("FAIL regen_sat got %0d want 120", mp); end
        checks++; if (magic !== 10'd122) begin errors++; $display("FAIL regen_magic got %0d want 122", magic); end
        tick(1'b0, 1'b1, 7'd10, 1'b0);
        n = 0;
        while (m_regen != REGEN_DIV - 1 && n < 1100) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            n++;
        end
        tick(1'b0, 1'b1, 7'd0, 1'b0);
        checks++; if ({cast_ok, mp} !== {1'b1, 7'd110}) begin errors++; $display("FAIL regen_castwrap got ok=%0b mp=%0d want ok=1 mp=110", cast_ok, mp); end
        idle(REGEN_DIV - 1);
        checks++; if (mp !== 7'd110) begin errors++; $display("FAIL regen_restart got %0d want 110", mp); end
        tick(1'b0, 1'b0, 7'd0, 1'b0);
        checks++; if (mp !== 7'd111) begin errors++; $display("FAIL regen_incr got %0d want 111", mp); end
    endtask

    task automatic test_priority();
        int prev;
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b1, 7'd80, 1'b0);
        wait_settled(600, "prio_setup");
        tick(1'b0, 1'b1, 7'd5, 1'b1);
        checks++; if (mp !== 7'd120) begin errors++; $display("FAIL prio_mp got %0d want 120", mp); end
        checks++; if ({cast_ok, cast_denied} !== 2'b00) begin errors++; $display("FAIL prio_pulses got %b want 00", {cast_ok, cast_denied}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prio_fill_busy got %0b want 1", busy); end
        idle(6);
        checks++; if (int'(magic) <= 42) begin errors++; $display("FAIL prio_filling got %0d want above 42", magic); end
        tick(1'b0, 1'b1, 7'd100, 1'b0);
        checks++; if ({cast_ok, mp} !== {1'b1, 7'd20}) begin errors++; $display("FAIL prio_rev_cast got ok=%0b mp=%0d want ok=1 mp=20", cast_ok, mp); end
        prev = int'(magic);
        for (int i = 0; i < 800 && busy === 1'b1; i++) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            if (int'(magic) != exp_magic()) begin
                checks++; errors++; $display("FAIL prio_rev_magic got %0d want %0d", magic, exp_magic());
            end
`ifndef MP_LOW_BLINK_EN
            checks++; if (int'(magic) > prev) begin errors++; $display("FAIL prio_rev_dir got %0d want at most %0d", magic, prev); end
`endif
            prev = int'(magic);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_rev_settle got %0b want 0", busy); end
        checks++; if (int'(magic) != exp_magic()) begin errors++; $display("FAIL prio_final_magic got %0d want %0d", magic, exp_magic()); end
    endtask

    task automatic test_reset_mid();
        int n;
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        wait_settled(600, "rstmid_setup");
        tick(1'b0, 1'b1, 7'd70, 1'b0);
        n = 0;
        while (magic !== 10'd100 && n < 300) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            n++;
        end
        checks++; if (magic !== 10'd100) begin errors++; $display("FAIL rstmid_reach got %0d want 100", magic); end
        tick(1'b1, 1'b0, 7'd0, 1'b0);
        checks++; if (magic !== 10'd122) begin errors++; $display("FAIL rstmid_magic got %0d want 122", magic); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        checks++; if (mp !== 7'd120) begin errors++; $display("FAIL rstmid_mp got %0d want 120", mp); end
    endtask

    task automatic test_empty();
        tick(1'b0, 1'b1, 7'd120, 1'b0);
        checks++; if ({cast_ok, mp, empty} !== {1'b1, 7'd0, 1'b1}) begin errors++; $display("FAIL empty_cast got ok=%0b mp=%0d empty=%0b want 1 0 1", cast_ok, mp, empty); end
        wait_settled(700, "empty");
        checks++; if (magic !== 10'd2) begin errors++; $display("FAIL empty_magic got %0d want 2", magic); end
    endtask

`ifdef MP_LOW_BLINK_EN
    task automatic test_blink();
        int saw2, saw22;
        tick(1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b1, 7'd100, 1'b0);
        wait_settled(600, "blink");
        saw2 = 0; saw22 = 0;
        for (int i = 0; i < 4 * BLINK_DIV; i++) begin
            tick(1'b0, 1'b0, 7'd0, 1'b0);
            checks++; if (int'(magic) != exp_magic()) begin errors++; $display("FAIL blink_magic got %0d want %0d", magic, exp_magic()); end
            if (magic == 10'd2) saw2++;
            if (magic == 10'd22) saw22++;
        end
        checks++; if (saw2 != 2 * BLINK_DIV || saw22 != 2 * BLINK_DIV) begin errors++; $display("FAIL blink_duty got %0d/%0d want %0d each", saw2, saw22, 2 * BLINK_DIV); end
    endtask
`endif

    task automatic test_random();
        logic c, s, r;
        logic [6:0] k;
        int pc;
        for (int i = 0; i < 4000; i++) begin
            pc = (i < 2000) ? 12 : 1;
            r = ($urandom_range(0, 999) < 2);
            s = ($urandom_range(0, 99) < 3);
            c = ($urandom_range(0, 99) < pc);
            k = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 40));
            tick(r, c, k, s);
            if (int'(mp) != m_mp || int'(magic) != exp_magic() || int'(busy) != exp_busy() ||
                int'(empty) != int'(m_mp == 0) || int'(cast_ok) != m_ok || int'(cast_denied) != m_den) begin
                checks++; errors++;
                $display("FAIL rand_c%0d got mp=%0d magic=%0d busy=%0b empty=%0b ok=%0b den=%0b want mp=%0d magic=%0d busy=%0d empty=%0d ok=%0d den=%0d",
                         i, mp, magic, busy, empty, cast_ok, cast_denied, m_mp, exp_magic(), exp_busy(), int'(m_mp == 0), m_ok, m_den);
            end else begin
                checks++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; cast = 1'b0; cost = 7'd0; restore = 1'b0;
        test_reset();
        test_cast_drain();
        test_back_to_back();
        test_denied();
        test_regen();
        test_priority();
        test_reset_mid();
        test_empty();
`ifdef MP_LOW_BLINK_EN
        test_blink();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
